smart_led_frame_controller: RTL
===============================

Name: smart_led_frame_controller

Overview:
- Sequences serial frame reception for one smart LED in a daisy chain.
- Synchronises the serial clock and data inputs, detects rising edges of the serial clock, and shifts in one 32-bit frame: 30 data bits, 1 use flag, 1 parity bit.
- Checks the frame and latches it. Then forwards all later traffic to the next LED until the line goes idle.
- Sits between the chip pins and the LED PWM/colour logic.

Parameters:
- IDLE_TIMEOUT, 1024, number of clk cycles with no in_clock rising edge after which the frame sequence ends (latch/reset gap).
- TIMEOUT_WIDTH, 11, width of the idle counter; must hold IDLE_TIMEOUT.

Ports:
- clk  input  1  global clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  1  serial data from the previous LED or host, asynchronous to clk
- in_clock  input  1  serial bit clock from upstream, asynchronous; data sampled on its rising edge
- out_data  output  1  forwarded serial data to the next LED
- out_clock  output  1  forwarded serial clock to the next LED
- frame_data  output  30  last accepted data payload
- frame_valid  output  1  one-cycle pulse when frame_data updates
- parity_error  output  1  one-cycle pulse on a parity failure
- frame_error  output  1  one-cycle pulse when a partial frame is discarded by timeout
- busy  output  1  high while in RECEIVE or FORWARD

Behaviour:
- Reset (async, rst_n=0): all outputs 0, frame_data=0, state IDLE, bit counter 0, parity 0, synchronisers 0, idle counter 0.
- Input synchronisation:
  - in_clock and in_data each pass through 2 flops.
  - edge = synced in_clock high AND previous synced value low.
  - The bit is captured on the clk edge after edge is detected, i.e. 3 clk edges after the pin rises.
  - Input constraint: in_clock high and low ≥2 clk periods each; in_data stable ≥3 clk periods before and after the in_clock rise.
- Shift order:
  - Each captured bit enters at bit 31 of a 32-bit shift register; the register shifts right.
  - The first bit received therefore ends at bit 0.
  - Frame layout after 32 bits: [29:0] data (data bit 0 sent first), [30] use flag, [31] parity.
  - Parity is even: XOR of all 32 bits must be 0. A running XOR resets at frame start.
- FSM states: IDLE, RECEIVE, FORWARD.
  - IDLE → RECEIVE on the first edge. That bit is captured and the bit count becomes 1.
  - RECEIVE: each edge captures one bit and increments the count.
  - On the 32nd capture the FSM goes to FORWARD and, on the same clk edge:
    - parity bad: parity_error=1; frame_data unchanged.
    - parity good, use flag=1: frame_data ← bits[29:0], frame_valid=1.
    - parity good, use flag=0: no output change and no pulse; the frame is consumed.
  - FORWARD: out_clock and out_data are registered copies of the synced inputs, 3 clk cycles pin-to-pin. Relative clock/data alignment is preserved.
  - In IDLE and RECEIVE, out_clock=0 and out_data=0. The controller's own frame is never forwarded.
- Idle counter:
  - Reset to 0 on every edge; otherwise increments, saturating at IDLE_TIMEOUT.
  - On reaching IDLE_TIMEOUT in RECEIVE: frame_error pulses, partial frame discarded, state → IDLE.
  - On reaching IDLE_TIMEOUT in FORWARD: state → IDLE silently.
  - In IDLE the counter has no effect.
  - If an edge occurs in the same cycle as timeout, the edge wins: it counts as a bit and the counter clears.
- Pulse outputs are high for exactly one clk cycle and never coincide with each other.
- busy = (state != IDLE), registered.
- Reset mid-frame: everything clears immediately, including frame_data. The next edge after release starts a new frame.

Test Plan:
- Reset, then send data=0x2AAAAAAA, use=1, correct parity bit → frame_valid pulses once, frame_data=0x2AAAAAAA, busy=1, out_clock stays 0 during the 32 bits.
- Same frame with the parity bit flipped → parity_error pulse, frame_valid never asserted, frame_data keeps its previous value.
- Good-parity frame with use=0, data=0x1234567 → no pulses, frame_data unchanged, FSM in FORWARD.
- First frame 0x3FFFFFFF/use=1, then a second frame 0x15555555 → second frame appears on out_clock/out_data bit-exact, 3 clk lag, frame_data stays 0x3FFFFFFF; after IDLE_TIMEOUT idle cycles busy=0 and out_clock=0.
- 17 bits then silence → frame_error pulse exactly IDLE_TIMEOUT cycles after the 17th capture; the next 32-bit frame is received normally from bit 0.
- Drive rst_n low after 20 bits of a frame → outputs 0 asynchronously; after release a full valid frame latches correctly.

Source files
------------

// File: rtl/smart_led_frame_controller.sv
// Serial frame receiver for one LED in a daisy chain: captures a 32-bit frame,
// checks even parity, latches the payload, then forwards later traffic until idle.
module smart_led_frame_controller #(
    parameter int IDLE_TIMEOUT  = 1024,
    parameter int TIMEOUT_WIDTH = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_data,
    input  logic        in_clock,
    output logic        out_data,
    output logic        out_clock,
    output logic [29:0] frame_data,
    output logic        frame_valid,
    output logic        parity_error,
    output logic        frame_error,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_FORWARD = 2'd2
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_VAL  = TIMEOUT_WIDTH'(IDLE_TIMEOUT);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(IDLE_TIMEOUT - 1);

    state_t                   state_q, state_d;
    logic                     in_clock_s1_q, in_clock_s2_q, in_clock_s3_q;
    logic                     in_data_s1_q, in_data_s2_q;
    logic [5:0]               bit_cnt_q, bit_cnt_d;
    logic                     parity_q, parity_d;
    logic [31:0]              shift_q, shift_d;
    logic [TIMEOUT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
    logic [29:0]              frame_data_q, frame_data_d;
    logic                     frame_valid_q, frame_valid_d;
    logic                     parity_error_q, parity_error_d;
    logic                     frame_error_q, frame_error_d;
    logic                     busy_q, busy_d;
    logic                     out_clock_q, out_clock_d;
    logic                     out_data_q, out_data_d;
    logic                     fwd_arm_q, fwd_arm_d;

    logic        edge_w;
    logic        timeout_w;
    logic [31:0] frame_w;

    assign edge_w    = in_clock_s2_q & ~in_clock_s3_q;
    assign timeout_w = ~edge_w & (idle_cnt_q == TIMEOUT_LAST);
    assign frame_w   = {in_data_s2_q, shift_q[31:1]};

    always_comb begin
        if (edge_w) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q == TIMEOUT_VAL) begin
            idle_cnt_d = idle_cnt_q;
        end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        parity_d       = parity_q;
        shift_d        = shift_q;
        frame_data_d   = frame_data_q;
        frame_valid_d  = 1'b0;
        parity_error_d = 1'b0;
        frame_error_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (edge_w) begin
                    state_d   = ST_RECEIVE;
                    bit_cnt_d = 6'd1;
                    parity_d  = in_data_s2_q;
                    shift_d   = frame_w;
                end
            end
            ST_RECEIVE: begin
                if (edge_w) begin
                    shift_d   = frame_w;
                    parity_d  = parity_q ^ in_data_s2_q;
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd31) begin
                        state_d   = ST_FORWARD;
                        bit_cnt_d = 6'd0;
                        parity_d  = 1'b0;
                        if (parity_q ^ in_data_s2_q) begin
                            parity_error_d = 1'b1;
                        end else if (frame_w[30]) begin
                            frame_data_d  = frame_w[29:0];
                            frame_valid_d = 1'b1;
                        end
                    end
                end else if (timeout_w) begin
                    // Partial frame is dropped; the next edge restarts at bit 0.
                    state_d       = ST_IDLE;
                    bit_cnt_d     = 6'd0;
                    parity_d      = 1'b0;
                    frame_error_d = 1'b1;
                end
            end
            ST_FORWARD: begin
                if (timeout_w) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The tail of our own 32nd clock pulse is still high on entry to FORWARD;
    // only pass clock pulses that start after a low has been seen.
    always_comb begin
        busy_d      = (state_d != ST_IDLE);
        fwd_arm_d   = (state_q == ST_FORWARD) & (fwd_arm_q | ~in_clock_s2_q);
        out_clock_d = (state_q == ST_FORWARD) & fwd_arm_q & in_clock_s2_q;
        out_data_d  = (state_q == ST_FORWARD) & in_data_s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            in_clock_s1_q  <= 1'b0;
            in_clock_s2_q  <= 1'b0;
            in_clock_s3_q  <= 1'b0;
            in_data_s1_q   <= 1'b0;
            in_data_s2_q   <= 1'b0;
            bit_cnt_q      <= '0;
            parity_q       <= 1'b0;
            shift_q        <= '0;
            idle_cnt_q     <= '0;
            frame_data_q   <= '0;
            frame_valid_q  <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
            busy_q         <= 1'b0;
            out_clock_q    <= 1'b0;
            out_data_q     <= 1'b0;
            fwd_arm_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            in_clock_s1_q  <= in_clock;
            in_clock_s2_q  <= in_clock_s1_q;
            in_clock_s3_q  <= in_clock_s2_q;
            in_data_s1_q   <= in_data;
            in_data_s2_q   <= in_data_s1_q;
            bit_cnt_q      <= bit_cnt_d;
            parity_q       <= parity_d;
            shift_q        <= shift_d;
            idle_cnt_q     <= idle_cnt_d;
            frame_data_q   <= frame_data_d;
            frame_valid_q  <= frame_valid_d;
            parity_error_q <= parity_error_d;
            frame_error_q  <= frame_error_d;
            busy_q         <= busy_d;
            out_clock_q    <= out_clock_d;
            out_data_q     <= out_data_d;
            fwd_arm_q      <= fwd_arm_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_clock    = out_clock_q;
    assign frame_data   = frame_data_q;
    assign frame_valid  = frame_valid_q;
    assign parity_error = parity_error_q;
    assign frame_error  = frame_error_q;
    assign busy         = busy_q;

endmodule
